// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit that sits between the CPU datapath and a
// word-wide synchronous data RAM. It turns byte-addressed loads and stores
// into word accesses. Sub-word stores are done as a read-modify-write.
// Load data is returned sign- or zero-extended. Misaligned or illegal
// sizes are reported as faults and never touch the RAM.
module mem_access_unit #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     we,
  input  logic [1:0]               size,
  input  logic                     sign_ext,
  input  logic [ADDRESS_WIDTH+1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     ready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rvalid,
  output logic                     wdone,
  output logic                     err,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rd
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_MERGE = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Request fields captured in the accept cycle. Later changes on addr/wdata
  // must not affect an access that is already in flight.
  logic [ADDRESS_WIDTH-1:0] word_addr_reg;
  logic [1:0]               off_reg;
  logic [1:0]               size_reg;
  logic                     sext_reg;
  logic [15:0]              wdata_reg;

  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  rvalid_reg, rvalid_next;
  logic                  wdone_reg, wdone_next;
  logic                  err_reg, err_next;

  logic                  accept;
  logic                  fault;
  logic [7:0]            rd_byte [4];
  logic [31:0]           merged_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           load_val;

  // Alignment and size check on the live request.
  always_comb begin
    fault = 1'b0;
    if (size == 2'b11)
      fault = 1'b1;
    else if (size == SZ_HALF && addr[0])
      fault = 1'b1;
    else if (size == SZ_WORD && addr[1:0] != 2'b00)
      fault = 1'b1;
  end

  // Per-lane views of the RAM word and the RMW merge. A byte store replaces
  // exactly one lane. A halfword store replaces the lane pair chosen by
  // offset bit 1.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam int HALF_SEL  = gi / 2;
    localparam int HALF_BYTE = gi % 2;
    logic       hit;
    logic [7:0] new_byte;
    assign rd_byte[gi] = ram_rd[8*gi +: 8];
    assign hit = (size_reg == SZ_BYTE && off_reg == 2'(gi)) ||
                 (size_reg == SZ_HALF && off_reg[1] == 1'(HALF_SEL));
    assign new_byte = (size_reg == SZ_HALF) ? wdata_reg[8*HALF_BYTE +: 8]
                                            : wdata_reg[7:0];
    assign merged_word[8*gi +: 8] = hit ? new_byte : ram_rd[8*gi +: 8];
  end

  // Lane select and extension of the returned RAM word for loads.
  always_comb begin
    sel_byte = rd_byte[off_reg];
    sel_half = off_reg[1] ? ram_rd[31:16] : ram_rd[15:0];
    case (size_reg)
      SZ_BYTE: load_val = {{24{sext_reg & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_val = {{16{sext_reg & sel_half[15]}}, sel_half};
      default: load_val = ram_rd;
    endcase
  end

  // Next-state logic, RAM drive and completion pulses.
  always_comb begin
    state_next  = state_reg;
    ready       = 1'b0;
    accept      = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    rdata_next  = rdata_reg;
    rvalid_next = 1'b0;
    wdone_next  = 1'b0;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          accept = 1'b1;
          if (fault) begin
            // Faults complete one cycle later and issue no RAM access.
            err_next    = 1'b1;
            rvalid_next = ~we;
            wdone_next  = we;
            if (!we)
              rdata_next = '0;
            state_next = DONE;
          end else if (!we) begin
            ram_en     = 1'b1;
            ram_addr   = addr[ADDRESS_WIDTH+1:2];
            state_next = LOAD_WAIT;
          end else if (size == SZ_WORD) begin
            ram_en     = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = addr[ADDRESS_WIDTH+1:2];
            ram_wdata  = wdata;
            wdone_next = 1'b1;
            state_next = DONE;
          end else begin
            // Sub-word store: read the word first, then merge and write it.
            ram_en     = 1'b1;
            ram_addr   = addr[ADDRESS_WIDTH+1:2];
            state_next = RMW_MERGE;
          end
        end
      end
      LOAD_WAIT: begin
        rdata_next  = load_val;
        rvalid_next = 1'b1;
        state_next  = DONE;
      end
      RMW_MERGE: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = word_addr_reg;
        ram_wdata  = merged_word;
        wdone_next = 1'b1;
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered result and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
      wdone_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rdata_reg  <= rdata_next;
      rvalid_reg <= rvalid_next;
      wdone_reg  <= wdone_next;
      err_reg    <= err_next;
    end
  end

  // Capture the request in the accept cycle for use by later states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_addr_reg <= '0;
      off_reg       <= 2'b00;
      size_reg      <= 2'b00;
      sext_reg      <= 1'b0;
      wdata_reg     <= '0;
    end else if (accept) begin
      word_addr_reg <= addr[ADDRESS_WIDTH+1:2];
      off_reg       <= addr[1:0];
      size_reg      <= size;
      sext_reg      <= sign_ext;
      wdata_reg     <= wdata[15:0];
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign wdone  = wdone_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It drives directed loads and stores against
// a behavioural synchronous RAM. A scoreboard queue holds the expected
// completions, and a monitor checks each rvalid/wdone pulse against it.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        wdone;
  logic        err;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rd = 32'h0;

  logic [31:0] mem [0:255];
  logic        preload;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_store;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .wdone    (wdone),
    .err      (err),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rd   (ram_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: 1-cycle synchronous read, write-first.
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h9420_6F2F;
      mem[1] <= 32'h0000_0000;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rd        <= ram_wdata;
      end else begin
        ram_rd <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expectation for every completion pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rvalid === 1'b1 || wdone === 1'b1)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: rvalid=%b wdone=%b with empty scoreboard (cycle %0d)",
                 rvalid, wdone, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_rvalid", 32'(rvalid), 32'(!e.is_store));
        chk("pulse_wdone", 32'(wdone), 32'(e.is_store));
        chk("pulse_err", 32'(err), 32'(e.err));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.is_store)
          chk("load_rdata", rdata, e.data);
      end
      $display("txn done cycle=%0d rvalid=%b wdone=%b err=%b rdata=%h", cyc, rvalid, wdone, err, rdata);
    end
  end

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk({nm, "_ready_timeout"}, 32'(ready), 32'd1);
  endtask

  // Issue one access and check the RAM-side activity in cycles N and N+1.
  // expv is the load result for loads and the merged RAM word for RMW stores.
  task automatic access(input string nm, input bit w, input logic [1:0] sz, input bit se,
                        input logic [9:0] a, input logic [31:0] wd,
                        input logic [31:0] expv, input bit experr);
    exp_t e;
    bit   rmw;
    bit   wstore;
    wait_ready(nm);
    rmw    = w && sz != 2'b10 && !experr;
    wstore = w && sz == 2'b10 && !experr;
    e.is_store = w;
    e.data     = expv;
    e.err      = experr;
    e.cyc      = cyc + ((experr || wstore) ? 1 : 2);
    sb.push_back(e);
    req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
    #1;
    chk({nm, "_N_ram_en"}, 32'(ram_en), 32'(!experr));
    if (!experr) begin
      chk({nm, "_N_ram_we"}, 32'(ram_we), 32'(wstore));
      chk({nm, "_N_ram_addr"}, 32'(ram_addr), 32'(a[9:2]));
      if (wstore) chk({nm, "_N_ram_wdata"}, ram_wdata, wd);
    end else begin
      chk({nm, "_N_ram_we"}, 32'(ram_we), 32'd0);
    end
    @(negedge clk);
    req = 1'b0; addr = ~a; wdata = ~wd;
    #1;
    if (rmw) begin
      chk({nm, "_N1_ram_we"}, 32'({ram_en, ram_we}), 32'b11);
      chk({nm, "_N1_ram_addr"}, 32'(ram_addr), 32'(a[9:2]));
      chk({nm, "_N1_ram_wdata"}, ram_wdata, expv);
    end else begin
      chk({nm, "_N1_ram_en"}, 32'(ram_en), 32'd0);
    end
    $display("txn issue %s we=%b size=%b addr=%h wdata=%h", nm, w, sz, a, wd);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; preload = 1'b1;
    req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulses", 32'({rvalid, wdone, err}), 32'd0);
    chk("rst_ram", 32'({ram_en, ram_we}), 32'd0);
    @(negedge clk);
    preload = 1'b0; rst_n = 1'b1;

    // Loads from the preloaded word 0 = 9420_6F2F.
    access("lb3_s",  0, 2'b00, 1, 10'd3, 32'h0, 32'hFFFF_FF94, 0);
    access("lbu3",   0, 2'b00, 0, 10'd3, 32'h0, 32'h0000_0094, 0);
    access("lb1_s",  0, 2'b00, 1, 10'd1, 32'h0, 32'h0000_006F, 0);
    access("lh2_s",  0, 2'b01, 1, 10'd2, 32'h0, 32'hFFFF_9420, 0);
    access("lhu0",   0, 2'b01, 0, 10'd0, 32'h0, 32'h0000_6F2F, 0);
    // Byte store via RMW, then read back.
    access("sb1",    1, 2'b00, 0, 10'd1, 32'h0000_00AB, 32'h9420_AB2F, 0);
    access("lw0",    0, 2'b10, 0, 10'd0, 32'h0, 32'h9420_AB2F, 0);
    // Word store, then read back.
    access("sw4",    1, 2'b10, 0, 10'd4, 32'hDEAD_BEEF, 32'h0, 0);
    access("lw4",    0, 2'b10, 0, 10'd4, 32'h0, 32'hDEAD_BEEF, 0);
    // Upper halfword store via RMW.
    access("sh6",    1, 2'b01, 0, 10'd6, 32'h0000_1234, 32'h1234_BEEF, 0);
    access("lh6_s",  0, 2'b01, 1, 10'd6, 32'h0, 32'h0000_1234, 0);
    access("lb5_s",  0, 2'b00, 1, 10'd5, 32'h0, 32'hFFFF_FFBE, 0);
    // Faults.
    access("lw2_f",  0, 2'b10, 0, 10'd2, 32'h0, 32'h0, 1);
    access("sh5_f",  1, 2'b01, 0, 10'd5, 32'h0000_5555, 32'h0, 1);
    access("lw4_chk",0, 2'b10, 0, 10'd4, 32'h0, 32'h1234_BEEF, 0);
    access("ld11_f", 0, 2'b11, 1, 10'd0, 32'h0, 32'h0, 1);
    access("st11_f", 1, 2'b11, 0, 10'd0, 32'h0000_0077, 32'h0, 1);
    access("lw0_b",  0, 2'b10, 0, 10'd0, 32'h0, 32'h9420_AB2F, 0);

    // req held high across a load: exactly two accepts, three cycles apart.
    wait_ready("b2b");
    e.is_store = 0; e.data = 32'h1234_BEEF; e.err = 0; e.cyc = cyc + 2;
    sb.push_back(e);
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 10'd4; wdata = '0;
    @(negedge clk); #1 chk("b2b_ready_n1", 32'(ready), 32'd0);
    @(negedge clk); #1 chk("b2b_ready_n2", 32'(ready), 32'd0);
    @(negedge clk); #1 chk("b2b_ready_n3", 32'(ready), 32'd1);
    e.cyc = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
    $display("txn issue b2b two held loads addr=004");

    // Reset asserted while the RMW write is pending.
    wait_ready("rst_rmw");
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 10'd1; wdata = 32'h0000_0055;
    #1 chk("rst_rmw_N_read", 32'({ram_en, ram_we}), 32'b10);
    @(negedge clk);
    req = 1'b0;
    #1 chk("rst_rmw_merge_we", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_ram", 32'({ram_en, ram_we}), 32'd0);
    chk("rst_rmw_ready", 32'(ready), 32'd1);
    chk("rst_rmw_rdata", rdata, 32'd0);
    chk("rst_rmw_pulses", 32'({rvalid, wdone, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn issue rst_rmw sb addr=001 abandoned by reset");
    access("lw0_after_rst", 0, 2'b10, 0, 10'd0, 32'h0, 32'h9420_AB2F, 0);

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit between the CPU datapath and the word-wide data memory RAM (DEPTH words, synchronous 1-cycle read, write-first).
- Converts byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests into word RAM accesses.
- Sub-word stores use a two-cycle read-modify-write (RMW).
- Returns sign- or zero-extended load data with a valid pulse, and flags misaligned or illegal accesses.

Parameters:
ADDRESS_WIDTH, 8, RAM word-address width; byte address is ADDRESS_WIDTH+2 bits.
DATA_WIDTH, 32, word width; fixed at 32, since lane logic assumes 4 bytes.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  1  access request, sampled when ready=1
we  input  1  1=store, 0=load
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
sign_ext  input  1  loads only: 1 sign-extends, 0 zero-extends
addr  input  ADDRESS_WIDTH+2  byte address
wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
ready  output  1  combinational; 1 only in IDLE
rdata  output  32  registered load result
rvalid  output  1  1-cycle pulse: load complete
wdone  output  1  1-cycle pulse: store complete
err  output  1  1-cycle pulse coincident with rvalid/wdone on a faulting access
ram_en  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDRESS_WIDTH  word address = addr[ADDRESS_WIDTH+1:2]
ram_wdata  output  32  RAM write data
ram_rd  input  32  RAM read data, valid the cycle after a read is issued

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rdata=0, rvalid=0, wdone=0, err=0. Any in-flight access is abandoned; an unissued RMW write never reaches the RAM.
- ram_en, ram_we, ram_addr and ram_wdata are 0 whenever no access is issued.
- Byte lanes are little-endian: offset = addr[1:0]; offset 0 maps to bits [7:0].
- Fault: size=11; halfword with addr[0]=1; word with addr[1:0]!=0.
  - A fault issues no RAM access (ram_en=0).
  - The next cycle pulses err with rvalid (load) or wdone (store); rdata is set to 0 on a load fault.
- States: IDLE, LOAD_WAIT, RMW_MERGE, DONE.
- Accept: req=1 in IDLE. RAM signals are driven combinationally in the accept cycle (cycle N).
  - Load: ram_en=1, ram_we=0. Next state LOAD_WAIT.
  - Word store: ram_en=1, ram_we=1, ram_wdata=wdata. Next state DONE; wdone=1 in N+1.
  - Sub-word store: ram_en=1, ram_we=0 (read for RMW). Captures offset, size and wdata. Next state RMW_MERGE.
  - Fault: next state DONE, with err set.
- LOAD_WAIT (N+1): select lane from ram_rd, extend per size/sign_ext, register into rdata. Next state DONE; rvalid=1 in N+2.
- RMW_MERGE (N+1): ram_en=1, ram_we=1, same ram_addr. ram_wdata = ram_rd with the selected byte or halfword lane replaced by the captured wdata. Next state DONE; wdone=1 in N+2.
- DONE: one cycle with the registered pulse(s) high; returns to IDLE. ready is 0 here, so the next accept is no earlier than N+3 (loads/RMW) or N+2 (word store/fault).
- req while ready=0 is ignored; the requester holds req until it sees ready=1.
- rdata holds its value until the next completed load.
- Latency:
  - Load: 2 cycles to rvalid.
  - Word store: 1 cycle to wdone.
  - Sub-word store: 2 cycles to wdone.
  - Fault: 1 cycle.
- addr/wdata are sampled only in the accept cycle; later changes have no effect.
- No address wrap logic: ram_addr is always a truncation of addr.

Test Plan:
- Preload word 0 = 32'h9420_6F2F.
  - LB addr=3 sign_ext=1 -> rvalid at N+2, rdata=32'hFFFF_FF94.
  - LBU addr=3 -> rdata=32'h0000_0094.
- LH addr=2 sign_ext=1 -> rdata=32'hFFFF_9420; LHU addr=0 -> rdata=32'h0000_6F2F.
- SB addr=1 wdata=32'h0000_00AB:
  - N: read of ram_addr=0; N+1: ram_we=1, ram_wdata=32'h9420_AB2F; N+2: wdone.
  - A subsequent LW addr=0 returns 32'h9420_AB2F.
- SW addr=4 wdata=32'hDEAD_BEEF -> ram_we=1 at N, wdone at N+1; LW addr=4 returns 32'hDEAD_BEEF.
- Faults:
  - LW addr=2 -> ram_en never 1, rvalid=err=1 at N+1, rdata=0.
  - SH addr=5 -> wdone=err=1 at N+1, memory unchanged.
  - size=11 -> err.
- Back-to-back and reset:
  - req held high across a load: second request accepted only when ready=1 again, no dropped or duplicated pulses.
  - rst_n=0 during RMW_MERGE -> no RAM write, outputs 0, state IDLE.
